// File: rtl/niosqs_oci_dct_pkg.sv
// Shared constants and types for the OCI direct-compressed-trace controller.
package niosqs_oci_dct_pkg;

  localparam int CODE_W  = 2;
  localparam int SLOTS   = 15;
  localparam int BUF_W   = CODE_W * SLOTS;
  localparam int CNT_W   = $clog2(SLOTS + 1);
  localparam int FRAME_W = CNT_W + BUF_W;
  localparam int DROP_W  = 8;

  typedef enum logic {
    E_IDLE  = 1'b0,
    E_VALID = 1'b1
  } emit_state_e;

  // Frame payload as seen by the trace sink: count in the top bits.
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] data;
  } frame_t;

  // Incoming trace code (cannot be stalled).
  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
  } code_req_t;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/niosqs_nios2_qsys_0_oci_dct_bank.sv
// One trace bank: packs codes LSB-first, tracks how many slots are used.
module niosqs_nios2_qsys_0_oci_dct_bank
  import niosqs_oci_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load,
  input  logic [BUF_W-1:0]  load_data,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              append,
  input  logic [CODE_W-1:0] code,
  output logic [BUF_W-1:0]  bank_data,
  output logic [CNT_W-1:0]  bank_cnt
);

  // Clear wins over load, load over append; append writes slot bank_cnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_data <= '0;
      bank_cnt  <= '0;
    end else if (clear) begin
      bank_data <= '0;
      bank_cnt  <= '0;
    end else if (load) begin
      bank_data <= load_data;
      bank_cnt  <= load_cnt;
    end else if (append && (bank_cnt < CNT_W'(SLOTS))) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (bank_cnt == CNT_W'(s)) bank_data[s*CODE_W +: CODE_W] <= code;
      end
      bank_cnt <= bank_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/niosqs_nios2_qsys_0_oci_dct_ctrl.sv
// Ping-pong DCT packer: one bank fills while the other is offered as a frame.
module niosqs_nios2_qsys_0_oci_dct_ctrl
  import niosqs_oci_dct_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code,
  input  logic               flush,
  output logic               frame_valid,
  output logic [FRAME_W-1:0] frame_data,
  input  logic               frame_ready,
  output logic [BUF_W-1:0]   dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  input  logic               ovf_clr
);

  localparam int NBANK = 2;

  logic                         sel;        // fill bank index, 0 = A
  logic                         flush_pend;
  emit_state_e                  state, state_nxt;
  code_req_t                    req;

  logic [NBANK-1:0][BUF_W-1:0]  bank_data;
  logic [NBANK-1:0][CNT_W-1:0]  bank_cnt;
  logic [NBANK-1:0]             bank_clear;
  logic [NBANK-1:0]             bank_append;

  logic [CNT_W-1:0]             fill_cnt;
  logic [CNT_W-1:0]             next_cnt;
  logic                         accept, drop, emit_free, handoff;
  frame_t                       emit_frame;

  assign req       = '{valid: code_valid, code: code};
  assign fill_cnt  = bank_cnt[sel];
  assign accept    = req.valid && (fill_cnt < CNT_W'(SLOTS));
  assign drop      = req.valid && !accept;
  assign next_cnt  = fill_cnt + CNT_W'(accept);
  assign emit_free = (state == E_IDLE) || frame_ready;
  // A bank is handed off when it is full or a flush is outstanding, and
  // only when the emit side can take it this cycle.
  assign handoff   = emit_free &&
                     ((next_cnt == CNT_W'(SLOTS)) ||
                      ((flush || flush_pend) && (next_cnt != '0)));

  // Fill bank appends; the outgoing emit bank becomes the new fill bank
  // and is zeroed on handoff. The parallel-load path is unused here.
  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    assign bank_append[g] = accept  && (sel == 1'(g));
    assign bank_clear[g]  = handoff && (sel != 1'(g));

    niosqs_nios2_qsys_0_oci_dct_bank u_bank (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (bank_clear[g]),
      .load      (1'b0),
      .load_data ('0),
      .load_cnt  ('0),
      .append    (bank_append[g]),
      .code      (req.code),
      .bank_data (bank_data[g]),
      .bank_cnt  (bank_cnt[g])
    );
  end

  // Emit FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= E_IDLE;
    else          state <= state_nxt;
  end

  // Emit FSM next state: a handoff always (re)arms the frame, a plain
  // transfer drops back to idle.
  always_comb begin
    state_nxt = state;
    if (handoff)                              state_nxt = E_VALID;
    else if (state == E_VALID && frame_ready) state_nxt = E_IDLE;
  end

  // Bank select and deferred flush tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      if (handoff) sel <= ~sel;
      if (handoff)                          flush_pend <= 1'b0;
      else if (flush && (next_cnt != '0))   flush_pend <= 1'b1;
    end
  end

  // Sticky overflow and saturating drop counter; a drop beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= ovf_clr ? DROP_W'(1) : sat_inc(drop_count);
    end else if (ovf_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  // Output muxes: live fill bank for the monitor, emit bank for the sink.
  always_comb begin
    emit_frame.cnt  = bank_cnt[~sel];
    emit_frame.data = bank_data[~sel];
    frame_valid     = (state == E_VALID);
    frame_data      = frame_valid ? emit_frame : '0;
    dct_buffer      = bank_data[sel];
    dct_count       = bank_cnt[sel];
  end

endmodule

// File: tb/tb_niosqs_nios2_qsys_0_oci_dct_ctrl.sv
// Directed bench for the DCT ping-pong controller.
module tb_niosqs_nios2_qsys_0_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        code_valid, flush, frame_ready, ovf_clr;
  logic [1:0]  code;
  logic        frame_valid, overflow;
  logic [33:0] frame_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  niosqs_nios2_qsys_0_oci_dct_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .code_valid  (code_valid),
    .code        (code),
    .flush       (flush),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_ready (frame_ready),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic [1:0]  c;
    logic        fl;
    logic        rdy;
    logic        clr;
    logic        vld;
    logic [33:0] fd;
    logic [29:0] db;
    logic [3:0]  dc;
    logic        ovf;
    logic [7:0]  drop;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cv, input logic [1:0] c, input logic fl,
                              input logic rdy, input logic vld, input logic [33:0] fd,
                              input logic [29:0] db, input logic [3:0] dc);
    vec_t v;
    v.cv = cv; v.c = c; v.fl = fl; v.rdy = rdy; v.clr = 1'b0;
    v.vld = vld; v.fd = fd; v.db = db; v.dc = dc; v.ovf = 1'b0; v.drop = 8'd0;
    return v;
  endfunction

  // Apply one cycle of inputs, then settle past the edge.
  task automatic drive(input logic cv, input logic [1:0] c, input logic fl,
                       input logic rdy, input logic clr);
    code_valid = cv; code = c; flush = fl; frame_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic vld, input logic [33:0] fd,
                     input logic [29:0] db, input logic [3:0] dc,
                     input logic ovf, input logic [7:0] drop);
    logic [77:0] act, exp;
    act = {frame_valid, frame_data, dct_buffer, dct_count, overflow, drop_count};
    exp = {vld, fd, db, dc, ovf, drop};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got vld=%b fd=%h db=%h dc=%0d ovf=%b drop=%0d, want vld=%b fd=%h db=%h dc=%0d ovf=%b drop=%0d",
               name, frame_valid, frame_data, dct_buffer, dct_count, overflow, drop_count,
               vld, fd, db, dc, ovf, drop);
    end
  endtask

  task automatic stream(input int n, input logic [1:0] c, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, c, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [29:0] pat15 [0:13];
    pat15 = '{30'h0, 30'h4, 30'h24, 30'hE4, 30'hE4, 30'h4E4, 30'h24E4, 30'hE4E4,
              30'hE4E4, 30'h4E4E4, 30'h24E4E4, 30'hE4E4E4, 30'hE4E4E4, 30'h4E4E4E4};

    // Full bank: codes 0,1,2,3,... with the sink always ready.
    for (int n = 0; n < 14; n++)
      tbl.push_back(mk(1'b1, 2'(n % 4), 1'b0, 1'b1, 1'b0, 34'h0, pat15[n], 4'(n + 1)));
    tbl.push_back(mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, {4'd15, 30'h24E4E4E4}, 30'h0, 4'd0));
    tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 34'h0, 30'h0, 4'd0));
    // Partial bank 3,2,1 then flush; second flush on empty bank does nothing.
    tbl.push_back(mk(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 34'h0, 30'h3,  4'd1));
    tbl.push_back(mk(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 34'h0, 30'hB,  4'd2));
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 34'h0, 30'h1B, 4'd3));
    tbl.push_back(mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {4'd3, 30'h1B}, 30'h0, 4'd0));
    tbl.push_back(mk(1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 34'h0, 30'h0, 4'd0));
    tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 34'h0, 30'h0, 4'd0));
    // Code and flush together at count 4: that code rides in the frame.
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 34'h0, 30'h1,  4'd1));
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 34'h0, 30'h5,  4'd2));
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 34'h0, 30'h15, 4'd3));
    tbl.push_back(mk(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 34'h0, 30'h55, 4'd4));
    tbl.push_back(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, {4'd5, 30'h255}, 30'h0, 4'd0));
    tbl.push_back(mk(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 34'h0, 30'h0, 4'd0));

    code_valid = 0; code = 0; flush = 0; frame_ready = 0; ovf_clr = 0;
    reset_n = 1'b0;
    #1;
    chk("reset_state", 0, 34'h0, 30'h0, 4'd0, 0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].cv, tbl[i].c, tbl[i].fl, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d", i), tbl[i].vld, tbl[i].fd, tbl[i].db, tbl[i].dc,
          tbl[i].ovf, tbl[i].drop);
    end

    // Sink stalled: A fills and waits, B fills, the rest are dropped.
    stream(15, 2'd1, 1'b0);
    chk("stall_a_full", 1, {4'd15, 30'h15555555}, 30'h0, 4'd0, 0, 8'd0);
    stream(15, 2'd2, 1'b0);
    chk("stall_b_full", 1, {4'd15, 30'h15555555}, 30'h2AAAAAAA, 4'd15, 0, 8'd0);
    stream(15, 2'd3, 1'b0);
    chk("drop_15", 1, {4'd15, 30'h15555555}, 30'h2AAAAAAA, 4'd15, 1, 8'd15);
    stream(250, 2'd3, 1'b0);
    chk("drop_saturate", 1, {4'd15, 30'h15555555}, 30'h2AAAAAAA, 4'd15, 1, 8'd255);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_drop", 1, {4'd15, 30'h15555555}, 30'h2AAAAAAA, 4'd15, 1, 8'd1);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("clr_only", 1, {4'd15, 30'h15555555}, 30'h2AAAAAAA, 4'd15, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("b2b_second", 1, {4'd15, 30'h2AAAAAAA}, 30'h0, 4'd0, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("b2b_done", 0, 34'h0, 30'h0, 4'd0, 0, 8'd0);

    // Flush while the emit bank is held: it is deferred and later codes join.
    stream(15, 2'd1, 1'b0);
    stream(2, 2'd3, 1'b0);
    chk("pend_pre", 1, {4'd15, 30'h15555555}, 30'hF, 4'd2, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("pend_flush", 1, {4'd15, 30'h15555555}, 30'hF, 4'd2, 0, 8'd0);
    stream(2, 2'd2, 1'b0);
    chk("pend_more", 1, {4'd15, 30'h15555555}, 30'hAF, 4'd4, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("pend_frame", 1, {4'd4, 30'hAF}, 30'h0, 4'd0, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("pend_taken", 0, 34'h0, 30'h0, 4'd0, 0, 8'd0);
    drive(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("pend_cleared", 0, 34'h0, 30'h1, 4'd1, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("flush_one", 1, {4'd1, 30'h1}, 30'h0, 4'd0, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a held frame.
    stream(15, 2'd1, 1'b0);
    stream(2, 2'd2, 1'b0);
    chk("pre_reset", 1, {4'd15, 30'h15555555}, 30'hA, 4'd2, 0, 8'd0);
    code_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", 0, 34'h0, 30'h0, 4'd0, 0, 8'd0);
    tests++;
    if (dut.sel !== 1'b0) begin
      fails++;
      $display("FAIL reset_sel: got %b want 0", dut.sel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stream(15, 2'd3, 1'b1);
    chk("post_reset_frame", 1, {4'd15, 30'h3FFFFFFF}, 30'h0, 4'd0, 0, 8'd0);
    drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("post_reset_idle", 0, 34'h0, 30'h0, 4'd0, 0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
